tag_lookup_nway: RTL and testbench

- Parametrised successor to the single 5-bit tag comparator: full N-way tag store for the set-associative cache.
- Holds tag and valid bits for every set/way and compares all ways in parallel.
- Tracks true LRU per set; on a miss it selects the victim way.
- Sits between the address splitter and the data-array controller; data array and memory are outside this block.

---
 rtl/tag_lookup_nway.sv | 245 ++++++++++++++++++++++++
 tb/tb_tag_lookup_nway.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_lookup_nway.sv
// ---------------------------------------------------------------------------
// tag_lookup_nway
//
// N-way set-associative tag store. For every set it keeps one tag and one
// valid bit per way, compares all ways of the addressed set in parallel and
// tracks true LRU with a per-way age (0 = most recent, WAYS-1 = least recent).
// On a miss it nominates a victim way: the lowest-numbered invalid way if
// there is one, otherwise the way with the oldest age.
//
// Operations (req_op):
//   00 LOOKUP : compare; a hit touches the way in the LRU order
//   01 FILL   : a tag that is already present is only touched; otherwise the
//               tag is written into the victim way, which is reported back
//               together with whatever valid line it displaced
//   10 INVAL  : clear the valid bit of the matching way
//   11 FLUSH  : walk every set, one per cycle, clearing valid bits and
//               restoring the reset age order; req_ready is low meanwhile
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready  request handshake; accepted when both are high
//   req_op               operation code (see above)
//   req_index, req_tag   set index and tag of the request
//   rsp_valid            one-cycle pulse, one cycle after acceptance
//   rsp_hit              the tag matched a valid way
//   rsp_way              hit way, or victim / written way on a miss
//   rsp_evict            a FILL displaced a valid line
//   rsp_evict_tag        tag of the displaced line (meaningful with rsp_evict)
// ---------------------------------------------------------------------------
module tag_lookup_nway #(
   parameter int TAG_W   = 5,
   parameter int INDEX_W = 3,
   parameter int WAYS    = 2,
   parameter int WAY_W   = $clog2(WAYS)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [1:0]         req_op,
   input  logic [INDEX_W-1:0] req_index,
   input  logic [TAG_W-1:0]   req_tag,
   output logic               rsp_valid,
   output logic               rsp_hit,
   output logic [WAY_W-1:0]   rsp_way,
   output logic               rsp_evict,
   output logic [TAG_W-1:0]   rsp_evict_tag
);

   localparam int SETS = 1 << INDEX_W;

   localparam logic [1:0] OP_LOOKUP = 2'b00;
   localparam logic [1:0] OP_FILL   = 2'b01;
   localparam logic [1:0] OP_INVAL  = 2'b10;
   localparam logic [1:0] OP_FLUSH  = 2'b11;

   typedef enum logic {
      ST_IDLE,
      ST_FLUSH
   } state_t;

   state_t state_q, state_d;
   logic [INDEX_W-1:0] flush_cnt_q, flush_cnt_d;

   logic [TAG_W-1:0] tag_q [SETS][WAYS];
   logic [TAG_W-1:0] tag_d [SETS][WAYS];
   logic [WAYS-1:0]  valid_q [SETS];
   logic [WAYS-1:0]  valid_d [SETS];
   logic [WAY_W-1:0] age_q [SETS][WAYS];
   logic [WAY_W-1:0] age_d [SETS][WAYS];

   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_hit_q, rsp_hit_d;
   logic [WAY_W-1:0] rsp_way_q, rsp_way_d;
   logic             rsp_evict_q, rsp_evict_d;
   logic [TAG_W-1:0] rsp_evict_tag_q, rsp_evict_tag_d;

   logic             accept;
   logic             hit_any;
   logic [WAY_W-1:0] hit_way;
   logic             inv_any;
   logic [WAY_W-1:0] inv_way;
   logic [WAY_W-1:0] lru_way;
   logic [WAY_W-1:0] victim_way;
   logic             touch_en;
   logic [WAY_W-1:0] touch_way;

   assign req_ready     = (state_q == ST_IDLE);
   assign accept        = req_valid && req_ready;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_hit       = rsp_hit_q;
   assign rsp_way       = rsp_way_q;
   assign rsp_evict     = rsp_evict_q;
   assign rsp_evict_tag = rsp_evict_tag_q;

   // Parallel compare and victim choice for the addressed set. Loops run from
   // the top way downwards so the lowest-numbered candidate is the last
   // assignment and therefore wins.
   always_comb begin
      hit_any = 1'b0;
      hit_way = '0;
      inv_any = 1'b0;
      inv_way = '0;
      lru_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid_q[req_index][w] && (tag_q[req_index][w] == req_tag)) begin
            hit_any = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!valid_q[req_index][w]) begin
            inv_any = 1'b1;
            inv_way = WAY_W'(w);
         end
         if (age_q[req_index][w] == WAY_W'(WAYS - 1)) begin
            lru_way = WAY_W'(w);
         end
      end
      victim_way = inv_any ? inv_way : lru_way;
   end

   // Request handling, flush walk and LRU maintenance.
   always_comb begin
      state_d         = state_q;
      flush_cnt_d     = flush_cnt_q;
      tag_d           = tag_q;
      valid_d         = valid_q;
      age_d           = age_q;
      rsp_valid_d     = 1'b0;
      rsp_hit_d       = rsp_hit_q;
      rsp_way_d       = rsp_way_q;
      rsp_evict_d     = rsp_evict_q;
      rsp_evict_tag_d = rsp_evict_tag_q;
      touch_en        = 1'b0;
      touch_way       = '0;

      if (state_q == ST_FLUSH) begin
         valid_d[flush_cnt_q] = '0;
         for (int w = 0; w < WAYS; w++) begin
            age_d[flush_cnt_q][w] = WAY_W'(w);
         end
         if (flush_cnt_q == INDEX_W'(SETS - 1)) begin
            state_d     = ST_IDLE;
            flush_cnt_d = '0;
            rsp_valid_d = 1'b1;
            rsp_hit_d   = 1'b0;
            rsp_way_d   = '0;
            rsp_evict_d = 1'b0;
         end else begin
            flush_cnt_d = flush_cnt_q + 1'b1;
         end
      end else if (accept) begin
         case (req_op)
            OP_LOOKUP: begin
               rsp_valid_d = 1'b1;
               rsp_evict_d = 1'b0;
               rsp_hit_d   = hit_any;
               rsp_way_d   = hit_any ? hit_way : victim_way;
               touch_en    = hit_any;
               touch_way   = hit_way;
            end
            OP_FILL: begin
               rsp_valid_d = 1'b1;
               if (hit_any) begin
                  rsp_hit_d   = 1'b1;
                  rsp_way_d   = hit_way;
                  rsp_evict_d = 1'b0;
                  touch_en    = 1'b1;
                  touch_way   = hit_way;
               end else begin
                  tag_d[req_index][victim_way]   = req_tag;
                  valid_d[req_index][victim_way] = 1'b1;
                  rsp_hit_d       = 1'b0;
                  rsp_way_d       = victim_way;
                  rsp_evict_d     = valid_q[req_index][victim_way];
                  rsp_evict_tag_d = tag_q[req_index][victim_way];
                  touch_en        = 1'b1;
                  touch_way       = victim_way;
               end
            end
            OP_INVAL: begin
               rsp_valid_d = 1'b1;
               rsp_evict_d = 1'b0;
               rsp_hit_d   = hit_any;
               rsp_way_d   = hit_any ? hit_way : victim_way;
               if (hit_any) begin
                  valid_d[req_index][hit_way] = 1'b0;
               end
            end
            OP_FLUSH: begin
               state_d     = ST_FLUSH;
               flush_cnt_d = '0;
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end

      // Touching way k ages every younger way by one and makes k the newest,
      // which keeps the ages of a set a permutation of 0..WAYS-1.
      if (touch_en) begin
         for (int w = 0; w < WAYS; w++) begin
            if (age_q[req_index][w] < age_q[req_index][touch_way]) begin
               age_d[req_index][w] = age_q[req_index][w] + 1'b1;
            end
         end
         age_d[req_index][touch_way] = '0;
      end
   end

   // Control, valid bits, ages and response registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= ST_IDLE;
         flush_cnt_q     <= '0;
         rsp_valid_q     <= 1'b0;
         rsp_hit_q       <= 1'b0;
         rsp_way_q       <= '0;
         rsp_evict_q     <= 1'b0;
         rsp_evict_tag_q <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            for (int w = 0; w < WAYS; w++) begin
               age_q[s][w] <= WAY_W'(w);
            end
         end
      end else begin
         state_q         <= state_d;
         flush_cnt_q     <= flush_cnt_d;
         rsp_valid_q     <= rsp_valid_d;
         rsp_hit_q       <= rsp_hit_d;
         rsp_way_q       <= rsp_way_d;
         rsp_evict_q     <= rsp_evict_d;
         rsp_evict_tag_q <= rsp_evict_tag_d;
         valid_q         <= valid_d;
         age_q           <= age_d;
      end
   end

   // Tag storage carries no reset; a tag is only meaningful with its valid bit.
   always_ff @(posedge clk) begin
      tag_q <= tag_d;
   end

endmodule

// File: tb/tb_tag_lookup_nway.sv
module tb_tag_lookup_nway;

   localparam logic [1:0] OP_LOOKUP = 2'b00;
   localparam logic [1:0] OP_FILL   = 2'b01;
   localparam logic [1:0] OP_INVAL  = 2'b10;
   localparam logic [1:0] OP_FLUSH  = 2'b11;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   // dut_a: TAG_W=5, INDEX_W=3, WAYS=2
   logic       a_req_valid = 1'b0;
   logic       a_req_ready;
   logic [1:0] a_req_op = 2'b00;
   logic [2:0] a_req_index = 3'd0;
   logic [4:0] a_req_tag = 5'd0;
   logic       a_rsp_valid, a_rsp_hit, a_rsp_way, a_rsp_evict;
   logic [4:0] a_rsp_evict_tag;

   // dut_b: TAG_W=8, INDEX_W=3, WAYS=4
   logic       b_req_valid = 1'b0;
   logic       b_req_ready;
   logic [1:0] b_req_op = 2'b00;
   logic [2:0] b_req_index = 3'd0;
   logic [7:0] b_req_tag = 8'd0;
   logic       b_rsp_valid, b_rsp_hit, b_rsp_evict;
   logic [1:0] b_rsp_way;
   logic [7:0] b_rsp_evict_tag;

   int checks = 0;
   int errors = 0;

   // Response tuples {valid, hit, way, evict, evict_tag}; evict_tag only
   // counts when evict is set.
   logic [8:0]  obs_a;
   logic [12:0] obs_b;
   logic [8:0]  exp_a;
   logic [12:0] exp_b;
   assign obs_a = {a_rsp_valid, a_rsp_hit, a_rsp_way, a_rsp_evict,
                   a_rsp_evict ? a_rsp_evict_tag : 5'h00};
   assign obs_b = {b_rsp_valid, b_rsp_hit, b_rsp_way, b_rsp_evict,
                   b_rsp_evict ? b_rsp_evict_tag : 8'h00};

   tag_lookup_nway dut_a (
      .clk(clk), .rst_n(rst_n),
      .req_valid(a_req_valid), .req_ready(a_req_ready), .req_op(a_req_op),
      .req_index(a_req_index), .req_tag(a_req_tag),
      .rsp_valid(a_rsp_valid), .rsp_hit(a_rsp_hit), .rsp_way(a_rsp_way),
      .rsp_evict(a_rsp_evict), .rsp_evict_tag(a_rsp_evict_tag)
   );

   tag_lookup_nway #(.TAG_W(8), .INDEX_W(3), .WAYS(4)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_op(b_req_op),
      .req_index(b_req_index), .req_tag(b_req_tag),
      .rsp_valid(b_rsp_valid), .rsp_hit(b_rsp_hit), .rsp_way(b_rsp_way),
      .rsp_evict(b_rsp_evict), .rsp_evict_tag(b_rsp_evict_tag)
   );

   always #5 clk = ~clk;

   // Present one request on a falling edge, let the next rising edge accept
   // it, and return on the following falling edge with the response visible.
   task automatic issue_a(input logic [1:0] op, input logic [2:0] idx, input logic [4:0] tag);
      @(negedge clk);
      a_req_valid = 1'b1; a_req_op = op; a_req_index = idx; a_req_tag = tag;
      @(negedge clk);
      a_req_valid = 1'b0;
   endtask

   task automatic issue_b(input logic [1:0] op, input logic [2:0] idx, input logic [7:0] tag);
      @(negedge clk);
      b_req_valid = 1'b1; b_req_op = op; b_req_index = idx; b_req_tag = tag;
      @(negedge clk);
      b_req_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++;
      if ({a_req_ready, obs_a, a_rsp_evict_tag} !== {1'b1, 9'h000, 5'h00}) begin
         errors++;
         $display("FAIL reset_a: got %b expected %b", {a_req_ready, obs_a, a_rsp_evict_tag}, {1'b1, 9'h000, 5'h00});
      end
      checks++;
      if ({b_req_ready, obs_b, b_rsp_evict_tag} !== {1'b1, 13'h0000, 8'h00}) begin
         errors++;
         $display("FAIL reset_b: got %b expected %b", {b_req_ready, obs_b, b_rsp_evict_tag}, {1'b1, 13'h0000, 8'h00});
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_lookup_miss();
      issue_a(OP_LOOKUP, 3'd3, 5'h12);
      exp_a = {1'b1, 1'b0, 1'b0, 1'b0, 5'h00};
      checks++;
      if (obs_a !== exp_a) begin errors++; $display("FAIL lookup_empty: got %b expected %b", obs_a, exp_a); end
      @(negedge clk);
      checks++;
      if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL rsp_pulse_width: got %b expected 0", a_rsp_valid); end
   endtask

   task automatic test_fill_lru();
      issue_a(OP_FILL, 3'd3, 5'h12);
      exp_a = {1'b1, 1'b0, 1'b0, 1'b0, 5'h00};
      checks++;
      if (obs_a !== exp_a) begin errors++; $display("FAIL fill_12: got %b expected %b", obs_a, exp_a); end
      issue_a(OP_FILL, 3'd3, 5'h07);
      exp_a = {1'b1, 1'b0, 1'b1, 1'b0, 5'h00};
      checks++;
      if (obs_a !== exp_a) begin errors++; $display("FAIL fill_07: got %b expected %b", obs_a, exp_a); end
      issue_a(OP_LOOKUP, 3'd3, 5'h12);
      exp_a = {1'b1, 1'b1, 1'b0, 1'b0, 5'h00};
      checks++;
      if (obs_a !== exp_a) begin errors++; $display("FAIL lookup_12_hit: got %b expected %b", obs_a, exp_a); end
      issue_a(OP_FILL, 3'd3, 5'h1F);
      exp_a = {1'b1, 1'b0, 1'b1, 1'b1, 5'h07};
      checks++;
      if (obs_a !== exp_a) begin errors++; $display("FAIL fill_1f_evict: got %b expected %b", obs_a, exp_a); end
      issue_a(OP_LOOKUP, 3'd3, 5'h07);
      exp_a = {1'b1, 1'b0, 1'b0, 1'b0, 5'h00};
      checks++;
      if (obs_a !== exp_a) begin errors++; $display("FAIL lookup_07_miss: got %b expected %b", obs_a, exp_a); end
   endtask

   task automatic test_fill_present_inval();
      issue_a(OP_FILL, 3'd3, 5'h12);
      exp_a = {1'b1, 1'b1, 1'b0, 1'b0, 5'h00};
      checks++;
      if (obs_a !== exp_a) begin errors++; $display("FAIL fill_present: got %b expected %b", obs_a, exp_a); end
      issue_a(OP_INVAL, 3'd3, 5'h12);
      exp_a = {1'b1, 1'b1, 1'b0, 1'b0, 5'h00};
      checks++;
      if (obs_a !== exp_a) begin errors++; $display("FAIL inval_12: got %b expected %b", obs_a, exp_a); end
      issue_a(OP_LOOKUP, 3'd3, 5'h12);
      exp_a = {1'b1, 1'b0, 1'b0, 1'b0, 5'h00};
      checks++;
      if (obs_a !== exp_a) begin errors++; $display("FAIL lookup_after_inval: got %b expected %b", obs_a, exp_a); end
      issue_a(OP_LOOKUP, 3'd3, 5'h1F);
      exp_a = {1'b1, 1'b1, 1'b1, 1'b0, 5'h00};
      checks++;
      if (obs_a !== exp_a) begin errors++; $display("FAIL lookup_1f_still: got %b expected %b", obs_a, exp_a); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      a_req_valid = 1'b1; a_req_op = OP_FILL; a_req_index = 3'd5; a_req_tag = 5'h0A;
      @(negedge clk);
      exp_a = {1'b1, 1'b0, 1'b0, 1'b0, 5'h00};
      checks++;
      if (obs_a !== exp_a) begin errors++; $display("FAIL b2b_fill: got %b expected %b", obs_a, exp_a); end
      a_req_op = OP_LOOKUP;
      @(negedge clk);
      exp_a = {1'b1, 1'b1, 1'b0, 1'b0, 5'h00};
      checks++;
      if (obs_a !== exp_a) begin errors++; $display("FAIL b2b_lookup_hit: got %b expected %b", obs_a, exp_a); end
      a_req_op = OP_INVAL;
      @(negedge clk);
      exp_a = {1'b1, 1'b1, 1'b0, 1'b0, 5'h00};
      checks++;
      if (obs_a !== exp_a) begin errors++; $display("FAIL b2b_inval: got %b expected %b", obs_a, exp_a); end
      a_req_op = OP_LOOKUP;
      @(negedge clk);
      a_req_valid = 1'b0;
      exp_a = {1'b1, 1'b0, 1'b0, 1'b0, 5'h00};
      checks++;
      if (obs_a !== exp_a) begin errors++; $display("FAIL b2b_lookup_miss: got %b expected %b", obs_a, exp_a); end
   endtask

   task automatic test_flush();
      int low;
      int pulses;
      issue_a(OP_FILL, 3'd0, 5'h01);
      issue_a(OP_FILL, 3'd7, 5'h01);
      @(negedge clk);
      a_req_valid = 1'b1; a_req_op = OP_FLUSH; a_req_index = 3'd0; a_req_tag = 5'h00;
      @(negedge clk);
      a_req_valid = 1'b0;
      low = 0;
      pulses = 0;
      while (a_req_ready !== 1'b1 && low < 40) begin
         if (a_rsp_valid === 1'b1) pulses++;
         low++;
         @(negedge clk);
      end
      checks++;
      if (low != 8) begin errors++; $display("FAIL flush_ready_low: got %0d cycles expected 8", low); end
      checks++;
      if (pulses != 0) begin errors++; $display("FAIL flush_early_rsp: got %0d pulses expected 0", pulses); end
      checks++;
      if ({a_rsp_valid, a_rsp_hit} !== 2'b10) begin errors++; $display("FAIL flush_rsp: got %b expected 10", {a_rsp_valid, a_rsp_hit}); end
      @(negedge clk);
      checks++;
      if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_rsp_single: got %b expected 0", a_rsp_valid); end
      issue_a(OP_LOOKUP, 3'd3, 5'h1F);
      exp_a = {1'b1, 1'b0, 1'b0, 1'b0, 5'h00};
      checks++;
      if (obs_a !== exp_a) begin errors++; $display("FAIL post_flush_set3: got %b expected %b", obs_a, exp_a); end
      issue_a(OP_LOOKUP, 3'd7, 5'h01);
      checks++;
      if (obs_a !== exp_a) begin errors++; $display("FAIL post_flush_set7: got %b expected %b", obs_a, exp_a); end
   endtask

   task automatic test_reset_mid_flush();
      int bad;
      issue_a(OP_FILL, 3'd6, 5'h03);
      issue_a(OP_FILL, 3'd6, 5'h04);
      exp_a = {1'b1, 1'b0, 1'b1, 1'b0, 5'h00};
      checks++;
      if (obs_a !== exp_a) begin errors++; $display("FAIL fill_set6_way1: got %b expected %b", obs_a, exp_a); end
      @(negedge clk);
      a_req_valid = 1'b1; a_req_op = OP_FLUSH;
      @(negedge clk);
      a_req_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({a_req_ready, obs_a, a_rsp_evict_tag} !== {1'b1, 9'h000, 5'h00}) begin
         errors++;
         $display("FAIL reset_mid_flush: got %b expected %b", {a_req_ready, obs_a, a_rsp_evict_tag}, {1'b1, 9'h000, 5'h00});
      end
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      repeat (12) begin
         @(negedge clk);
         if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL after_reset_idle: got %0d bad cycles expected 0", bad); end
      issue_a(OP_LOOKUP, 3'd6, 5'h03);
      exp_a = {1'b1, 1'b0, 1'b0, 1'b0, 5'h00};
      checks++;
      if (obs_a !== exp_a) begin errors++; $display("FAIL set6_cleared: got %b expected %b", obs_a, exp_a); end
   endtask

   task automatic test_lru_4way();
      logic [7:0] tags [8];
      tags = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
      for (int i = 0; i < 4; i++) begin
         issue_b(OP_FILL, 3'd4, tags[i]);
         exp_b = {1'b1, 1'b0, 2'(i), 1'b0, 8'h00};
         checks++;
         if (obs_b !== exp_b) begin errors++; $display("FAIL b_fill_%0d: got %b expected %b", i, obs_b, exp_b); end
      end
      for (int i = 4; i < 8; i++) begin
         issue_b(OP_FILL, 3'd4, tags[i]);
         exp_b = {1'b1, 1'b0, 2'(i - 4), 1'b1, tags[i-4]};
         checks++;
         if (obs_b !== exp_b) begin errors++; $display("FAIL b_evict_%0d: got %b expected %b", i, obs_b, exp_b); end
      end
      issue_b(OP_LOOKUP, 3'd4, 8'h10);
      exp_b = {1'b1, 1'b0, 2'd0, 1'b0, 8'h00};
      checks++;
      if (obs_b !== exp_b) begin errors++; $display("FAIL b_lookup_10_miss: got %b expected %b", obs_b, exp_b); end
      issue_b(OP_LOOKUP, 3'd4, 8'h50);
      exp_b = {1'b1, 1'b1, 2'd0, 1'b0, 8'h00};
      checks++;
      if (obs_b !== exp_b) begin errors++; $display("FAIL b_lookup_50_hit: got %b expected %b", obs_b, exp_b); end
      issue_b(OP_FILL, 3'd4, 8'h90);
      exp_b = {1'b1, 1'b0, 2'd1, 1'b1, 8'h60};
      checks++;
      if (obs_b !== exp_b) begin errors++; $display("FAIL b_fill_90_after_touch: got %b expected %b", obs_b, exp_b); end
      issue_b(OP_INVAL, 3'd4, 8'h70);
      exp_b = {1'b1, 1'b1, 2'd2, 1'b0, 8'h00};
      checks++;
      if (obs_b !== exp_b) begin errors++; $display("FAIL b_inval_70: got %b expected %b", obs_b, exp_b); end
      issue_b(OP_FILL, 3'd4, 8'hA0);
      exp_b = {1'b1, 1'b0, 2'd2, 1'b0, 8'h00};
      checks++;
      if (obs_b !== exp_b) begin errors++; $display("FAIL b_fill_invalid_way: got %b expected %b", obs_b, exp_b); end
   endtask

   task automatic test_flush_4way();
      int low;
      @(negedge clk);
      b_req_valid = 1'b1; b_req_op = OP_FLUSH;
      @(negedge clk);
      b_req_valid = 1'b0;
      low = 0;
      while (b_req_ready !== 1'b1 && low < 40) begin
         low++;
         @(negedge clk);
      end
      checks++;
      if (low != 8 || b_rsp_valid !== 1'b1) begin
         errors++;
         $display("FAIL b_flush: got %0d cycles rsp_valid %b expected 8 cycles rsp_valid 1", low, b_rsp_valid);
      end
      issue_b(OP_LOOKUP, 3'd4, 8'h50);
      exp_b = {1'b1, 1'b0, 2'd0, 1'b0, 8'h00};
      checks++;
      if (obs_b !== exp_b) begin errors++; $display("FAIL b_post_flush: got %b expected %b", obs_b, exp_b); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_lookup_miss();
      test_fill_lru();
      test_fill_present_inval();
      test_back_to_back();
      test_flush();
      test_reset_mid_flush();
      test_lru_4way();
      test_flush_4way();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
